// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike core.
// The fetch stage takes its PC type, state encoding and NOP word from here.
package risc_v_mike_pkg;

   typedef logic [31:0] t_pc_addr;

   typedef enum logic [1:0] {
      S_BOOT,
      S_FETCH,
      S_HALT
   } t_fetch_state;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'd4;

   function automatic logic is_word_aligned(input t_pc_addr addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/risc_v_mike_fetch_fifo.sv
// Small FIFO with registered storage. It buffers fetched {instr, pc} words for decode.
// A flush empties the FIFO and takes priority over any push or pop in the same cycle.
module risc_v_mike_fetch_fifo #(
   parameter int                 WIDTH      = 64,
   parameter int                 DEPTH      = 2,
   parameter logic [WIDTH-1:0]   RESET_WORD = '0,
   localparam int                PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int                CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             full
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // A full FIFO can still accept a push in the same cycle as a pop.
   assign do_pop  = pop && (count_q != '0) && !flush;
   assign do_push = push && !flush && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= RESET_WORD;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/risc_v_mike_fetch_unit.sv
// Instruction fetch stage. It owns the PC, drives the combinational imem, and buffers words for decode.
// A misaligned redirect halts fetch until reset.
module risc_v_mike_fetch_unit
   import risc_v_mike_pkg::*;
#(
   parameter t_pc_addr RESET_PC   = 32'h0000_0000,
   parameter int       FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output t_pc_addr    imem_addr,
   input  logic [31:0] imem_rd_data,
   input  logic        redirect_valid,
   input  t_pc_addr    redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output t_pc_addr    if_pc,
   output logic        misalign_err,
   output logic [31:0] fetch_count
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   t_fetch_state state_q, state_d;
   t_pc_addr     pc_q, pc_d;
   logic         misalign_err_q, misalign_err_d;
   logic [31:0]  fetch_count_q, fetch_count_d;

   logic             fifo_push;
   logic             fifo_flush;
   logic             fifo_full;
   logic             pop_fire;
   logic [CNT_W-1:0] fifo_count;
   logic [63:0]      fifo_dout;

   risc_v_mike_fetch_fifo #(
      .WIDTH      (64),
      .DEPTH      (FIFO_DEPTH),
      .RESET_WORD ({NOP_INSTR, RESET_PC})
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (pop_fire),
      .flush (fifo_flush),
      .din   ({imem_rd_data, pc_q}),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full)
   );

   assign if_valid     = (fifo_count != '0);
   assign pop_fire     = if_valid && if_ready;
   assign if_instr     = fifo_dout[63:32];
   assign if_pc        = fifo_dout[31:0];
   assign imem_addr    = pc_q;
   assign misalign_err = misalign_err_q;
   assign fetch_count  = fetch_count_q;

   // A pop in a redirect cycle is still counted since decode already consumed it.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      misalign_err_d = misalign_err_q;
      fetch_count_d  = fetch_count_q;
      fifo_push      = 1'b0;
      fifo_flush     = 1'b0;
      if (pop_fire) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end
      case (state_q)
         S_BOOT: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (redirect_valid) begin
               fifo_flush = 1'b1;
               if (is_word_aligned(redirect_pc)) begin
                  pc_d = redirect_pc;
               end else begin
                  misalign_err_d = 1'b1;
                  state_d        = S_HALT;
               end
            end else if (!fifo_full || pop_fire) begin
               fifo_push = 1'b1;
               pc_d      = pc_q + PC_STEP;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_BOOT;
         pc_q           <= RESET_PC;
         misalign_err_q <= 1'b0;
         fetch_count_q  <= 32'd0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         misalign_err_q <= misalign_err_d;
         fetch_count_q  <= fetch_count_d;
      end
   end

endmodule

// File: doc/risc_v_mike_fetch_unit.md
# risc_v_mike_fetch_unit

Instruction fetch stage: owns the program counter, drives the address of the combinational-read instruction memory, and captures each returned word together with its PC into a small FIFO. The FIFO is drained by decode over a valid/ready handshake. Sits directly upstream of the instruction memory and between it and decode. Execute redirects it on taken branches and jumps.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- FIFO_DEPTH, 2, fetch buffer entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_addr  out  t_pc_addr  byte address to instruction memory; equals pc register
- imem_rd_data  in  32  instruction word for imem_addr, same cycle (combinational memory)
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_pc  in  t_pc_addr  new PC target
- if_valid  out  1  FIFO head holds a valid instruction
- if_ready  in  1  decode accepts head this cycle
- if_instr  out  32  head instruction word
- if_pc  out  t_pc_addr  PC of head instruction
- misalign_err  out  1  sticky; redirect target not word-aligned
- fetch_count  out  32  instructions handed to decode (wrapping)

## Operation
- States: S_BOOT, S_FETCH, S_HALT.
- S_BOOT: entered on reset. Lasts one cycle after rst deasserts, then moves to S_FETCH. No push.
- S_FETCH: push {imem_rd_data, pc} when push_ok = (count < FIFO_DEPTH) || (if_valid && if_ready). On push, pc <= pc + 4, which wraps modulo 2^32. Without a push, pc holds.
- Pop: occurs when if_valid && if_ready. fetch_count increments on each pop.
- Redirect, aligned (redirect_pc[1:0] == 0):
  - Flush the FIFO (count <= 0) and set pc <= redirect_pc.
  - Suppress this cycle's push.
  - A pop in the same cycle is still counted, because decode already took it.
  - Redirect has priority over push.
- Redirect, misaligned: set misalign_err, flush the FIFO, go to S_HALT. pc keeps its old value.
- S_HALT: no pushes and no redirects. if_valid = 0. Only reset leaves this state.
- if_valid = (count != 0). if_instr and if_pc come from registered FIFO storage.
- The FIFO makes no combinational path from any input to if_valid, if_instr or if_pc.

## Timing
- Reset values:
  - pc = RESET_PC, state = S_BOOT, count = 0, read/write pointers = 0.
  - if_valid = 0, if_instr = 32'h0000_0013 (NOP), if_pc = RESET_PC.
  - misalign_err = 0, fetch_count = 0.
  - imem_addr = RESET_PC.
- Latency: the word at PC p is pushed in the cycle imem_addr = p. if_valid for it rises on the next edge, so fetch-to-decode is 1 cycle.
- Throughput: 1 instruction per cycle when if_ready is held high. Full with a simultaneous pop still pushes.
- Full without a pop: pc and imem_addr hold and nothing is lost.
- Redirect asserted in cycle N:
  - imem_addr = redirect_pc in cycle N+1.
  - The first redirected instruction is valid in N+2.
  - if_valid = 0 in N+1.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Any FIFO contents are lost.
- Empty FIFO with if_ready high: nothing happens and fetch_count is unchanged.

## Structure
- Additions to risc_v_mike_pkg:
  - typedef t_fetch_state {S_BOOT, S_FETCH, S_HALT}
  - constant NOP_INSTR = 32'h0000_0013
  - constant PC_STEP = 4
  - t_pc_addr is reused.
- Sub-module risc_v_mike_fetch_fifo:
  - Parameterised width/depth, registered storage, read/write pointers, count.
  - Ports: push, pop, flush, din, dout, count, full.
  - flush overrides push.
- The top level holds pc, the state machine, misalign_err and fetch_count.

## Test plan
- Reset release, if_ready = 1, imem model returns 32'hAAAA_0000 | addr:
  - if_pc sequence 0, 4, 8, … starting the second cycle after S_BOOT.
  - if_instr matches each if_pc.
- if_ready = 0 for 5 cycles:
  - FIFO fills at 2 entries and imem_addr freezes at 8.
  - On release, entries 0 and 4 drain in order, then 8, with no gap or duplicate.
- Redirect to 32'h40 while FIFO holds 2 entries:
  - if_valid = 0 next cycle, imem_addr = 32'h40.
  - if_pc = 32'h40 the cycle after.
  - fetch_count is unchanged by the flushed entries.
- Redirect to 32'h42:
  - misalign_err = 1 sticky, if_valid stays 0, imem_addr frozen.
  - A later aligned redirect is ignored until rst is pulsed low.
- pc = 32'hFFFF_FFFC with continuous fetch: next imem_addr = 0 (wrap).
- rst pulsed low mid-stream with 2 entries buffered: outputs return to reset values asynchronously and fetch restarts at RESET_PC.
